// File: rtl/pipe_ctrl_pkg.sv
// Shared execution-control definitions: FSM state encoding and special opcodes.
// Used by the execution controller, the debug unit and the ID decoder.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_NOP  = 6'b000000;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction in ID. Writes to $zero never create a hazard.
module load_use_detect #(
  parameter int NB_REG = 5
) (
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic [NB_REG-1:0] i_ex_rt,
  input  logic              i_ex_mem_read,
  output logic              stall
);

  assign stall = i_ex_mem_read && (i_ex_rt != '0) &&
                 ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Five-stage pipeline execution controller: run/step/halt sequencing, load-use
// bubbles and HALT drain. Optional cycle counter under PIPE_EXEC_CTRL_CYCLE_COUNT_EN.
module pipe_exec_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NB_OP        = 6,
  parameter int NB_REG       = 5,
  parameter int NB_CYCLE     = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_step,
  input  logic [NB_OP-1:0]    i_id_opcode,
  input  logic [NB_REG-1:0]   i_id_rs,
  input  logic [NB_REG-1:0]   i_id_rt,
  input  logic [NB_REG-1:0]   i_ex_rt,
  input  logic                i_ex_mem_read,
  output logic                o_pc_enable,
  output logic                o_if_id_enable,
  output logic                o_id_ex_flush,
  output logic                o_pipe_enable,
  output logic                o_busy,
  output logic                o_halted,
  output logic [NB_CYCLE-1:0] o_cycle_count
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic       stall, halt;

  load_use_detect #(.NB_REG(NB_REG)) u_hazard (
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_ex_rt       (i_ex_rt),
    .i_ex_mem_read (i_ex_mem_read),
    .stall         (stall)
  );

  // A stalled HALT is not yet committed; it is seen again once the bubble clears.
  assign halt = (i_id_opcode == NB_OP'(OP_HALT)) && !stall;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    o_pc_enable    = 1'b0;
    o_if_id_enable = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_pipe_enable  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_run)       state_d = ST_RUN;
        else if (i_step) state_d = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        o_pipe_enable  = 1'b1;
        o_pc_enable    = !stall && !halt;
        o_if_id_enable = !stall && !halt;
        o_id_ex_flush  = stall;
        if (halt) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end else if (state_q == ST_STEP) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        o_pipe_enable = 1'b1;
        o_id_ex_flush = 1'b1;
        if (drain_q == '0) state_d = ST_HALTED;
        else               drain_d = drain_q - 4'd1;
      end
      ST_HALTED: ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy   = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
  assign o_halted = (state_q == ST_HALTED);

`ifdef PIPE_EXEC_CTRL_CYCLE_COUNT_EN
  logic [NB_CYCLE-1:0] cycle_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                          cycle_q <= '0;
    else if (o_pipe_enable && !(&cycle_q)) cycle_q <= cycle_q + 1'b1;
  end

  assign o_cycle_count = cycle_q;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Scoreboard bench for pipe_exec_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_pipe_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0, step = 1'b0, mr = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [4:0]  rs = 5'd0, rt = 5'd0, exrt = 5'd0;
  logic        pc_en, ifid_en, flush, pipe_en, busy, halted;
  logic [31:0] cc;

  typedef struct {
    logic [5:0]  flags;  // {pc, if_id, flush, pipe, busy, halted}
    logic [31:0] cc;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0, cyc_id = 0;

  always #5 clk = ~clk;

  pipe_exec_ctrl dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_run          (run),
    .i_step         (step),
    .i_id_opcode    (op),
    .i_id_rs        (rs),
    .i_id_rt        (rt),
    .i_ex_rt        (exrt),
    .i_ex_mem_read  (mr),
    .o_pc_enable    (pc_en),
    .o_if_id_enable (ifid_en),
    .o_id_ex_flush  (flush),
    .o_pipe_enable  (pipe_en),
    .o_busy         (busy),
    .o_halted       (halted),
    .o_cycle_count  (cc)
  );

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [5:0] act;
      e   = q.pop_front();
      act = {pc_en, ifid_en, flush, pipe_en, busy, halted};
      checks++;
      if (act !== e.flags) begin
        errors++;
        $display("FAIL flags cyc%0d: got %b expected %b", e.id, act, e.flags);
      end
      checks++;
      if (cc !== e.cc) begin
        errors++;
        $display("FAIL cycle_count cyc%0d: got %0d expected %0d", e.id, cc, e.cc);
      end
    end
  end

  // One clock cycle of stimulus; arst asserts reset asynchronously mid-cycle.
  task automatic cyc(input logic r, input logic ru, input logic st, input logic [5:0] o,
                     input logic [4:0] s, input logic [4:0] t, input logic [4:0] x,
                     input logic m, input logic [5:0] flags, input int cnt,
                     input bit arst = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; run = ru; step = st; op = o; rs = s; rt = t; exrt = x; mr = m;
    e.flags = flags;
`ifdef PIPE_EXEC_CTRL_CYCLE_COUNT_EN
    e.cc = 32'(cnt);
`else
    e.cc = (cnt >= 0) ? 32'd0 : 32'd0;
`endif
    e.id = cyc_id++;
    q.push_back(e);
    if (arst) begin
      #2 rst = 1'b1;
    end
  endtask

  localparam logic [5:0] H = 6'b111111;

  initial begin
    //   rst run stp op  rs rt exrt mr  flags      cc
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);  // reset
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 0);  // IDLE samples run
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b110110, 0);  // RUN
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b110110, 1);
    cyc(0, 0, 0, 0, 5, 0, 5, 1, 6'b001110, 2);  // load-use via rs
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b110110, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 6'b110110, 4);  // load to $zero: no stall
    cyc(0, 0, 0, 0, 1, 5, 5, 1, 6'b001110, 5);  // load-use via rt
    cyc(0, 0, 0, H, 5, 0, 5, 1, 6'b001110, 6);  // HALT + hazard: stall wins
    cyc(0, 0, 0, H, 0, 0, 0, 0, 6'b000110, 7);  // halt at t
    cyc(0, 1, 0, H, 0, 0, 0, 0, 6'b001110, 8);  // DRAIN t+1, run ignored
    cyc(0, 0, 1, H, 0, 0, 0, 0, 6'b001110, 9);  // DRAIN t+2
    cyc(0, 0, 0, H, 0, 0, 0, 0, 6'b001110, 10); // DRAIN t+3
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 6'b000001, 11); // HALTED t+4
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 6'b000001, 11);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 11);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);  // reset leaves HALTED
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 6'b000000, 0);  // step #1 sampled
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b110110, 0);  // STEP
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1);  // IDLE
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 6'b000000, 1);  // step #2 sampled
    cyc(0, 0, 0, 0, 3, 0, 3, 1, 6'b001110, 1);  // STEP with stall
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 6'b000000, 2);  // IDLE, step #3 sampled
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b110110, 2);  // STEP
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 6'b000000, 3);  // run beats step
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b110110, 3);  // RUN
    cyc(0, 0, 0, H, 0, 0, 0, 0, 6'b000110, 4);  // halt
    cyc(0, 0, 0, H, 0, 0, 0, 0, 6'b001110, 5);  // DRAIN 1
    cyc(0, 0, 0, H, 0, 0, 0, 0, 6'b000000, 0, 1'b1); // DRAIN 2, async reset
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 0);  // IDLE, fresh run
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b110110, 0);  // RUN again
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'b110110, 1);
    begin
      int budget = 20;
      while (q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain_queue: got %0d pending expected 0", q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_exec_ctrl.md
# pipe_exec_ctrl

Execution controller for the five-stage MIPS pipeline: it sequences the IF/ID/EX/MEM/WB registers around the EX datapath. It accepts run and single-step commands and freezes fetch on a load-use hazard while injecting a bubble into ID/EX. On a HALT opcode it stops fetch, drains the instructions already in flight, and parks in a halted state. It sits beside the debug unit and drives the enable and flush inputs of every pipeline register.

## Interface
- NB_OP, 6, opcode width
- NB_REG, 5, register-address width
- NB_CYCLE, 32, cycle-counter width
- DRAIN_CYCLES, 3, number of cycles spent in DRAIN (valid range 1..15)
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_run  in  1  start continuous execution; level sampled on the clock edge
- i_step  in  1  advance exactly one pipeline cycle
- i_id_opcode  in  NB_OP  opcode of the instruction currently in ID
- i_id_rs, i_id_rt  in  NB_REG  source registers of the instruction in ID
- i_ex_rt  in  NB_REG  destination register of the instruction in EX
- i_ex_mem_read  in  1  instruction in EX is a load
- o_pc_enable  out  1  PC register update enable
- o_if_id_enable  out  1  IF/ID register enable
- o_id_ex_flush  out  1  load NOP into ID/EX this cycle
- o_pipe_enable  out  1  enable for ID/EX, EX/MEM and MEM/WB
- o_busy  out  1  high in RUN, STEP and DRAIN
- o_halted  out  1  high in HALTED
- o_cycle_count  out  NB_CYCLE  count of enabled pipeline cycles

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED.
- Hazard (combinational): `stall = i_ex_mem_read && i_ex_rt != 0 && (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt)`.
- Halt detect (combinational): `halt = (i_id_opcode == OP_HALT) && !stall`.

**IDLE**
- All enables and flush are 0.
- i_run → RUN. Otherwise i_step → STEP. i_run has priority when both are high.

**RUN**
- o_pipe_enable = 1.
- o_pc_enable = o_if_id_enable = !stall && !halt.
- o_id_ex_flush = stall.
- halt → DRAIN, with the drain counter loaded to DRAIN_CYCLES-1. Otherwise RUN persists; i_run is not required to stay high.

**STEP**
- Outputs are identical to RUN for exactly one cycle.
- Then → DRAIN if halt, else → IDLE.
- A stall in STEP still consumes the step: the bubble is inserted and the PC does not advance.

**DRAIN**
- o_pipe_enable = 1, o_id_ex_flush = 1, o_pc_enable = o_if_id_enable = 0.
- The HALT instruction stays frozen in IF/ID; NOPs follow it into EX.
- The counter decrements each cycle. At counter = 0 → HALTED.
- i_run and i_step are ignored.

**HALTED**
- All enables and flush are 0; o_halted = 1.
- Terminal state; only i_reset leaves it.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE
  - drain counter = 0
  - o_cycle_count = 0
  - all enables, o_id_ex_flush, o_busy and o_halted = 0
- Enables and flush are Mealy outputs: combinational from current state plus same-cycle ID/EX inputs, with no extra latency.
- o_busy and o_halted are Moore outputs decoded from state.
- The first enabled cycle is the cycle after the edge on which i_run or i_step is sampled.
- The stall lasts exactly as long as the hazard condition holds, normally one cycle. A load with i_ex_rt = 0 never stalls.
- HALT in ID at cycle t:
  - ID/EX captures HALT at the end of t.
  - DRAIN occupies t+1 .. t+DRAIN_CYCLES.
  - o_halted rises at t+DRAIN_CYCLES+1.
- A hazard and a HALT opcode in the same cycle resolve as stall first; halt is detected on the following cycle.
- Reset asserted mid-DRAIN or mid-STEP aborts to IDLE with no residual enable.

## Configuration
- PIPE_EXEC_CTRL_CYCLE_COUNT_EN defined:
  - o_cycle_count increments on every cycle with o_pipe_enable = 1.
  - It saturates at all-ones.
  - It is cleared only by reset.
- PIPE_EXEC_CTRL_CYCLE_COUNT_EN undefined: no counter register is synthesized and o_cycle_count is constant 0.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state encoding (3-bit enum: IDLE, RUN, STEP, DRAIN, HALTED)
  - OP_HALT = 6'b111111
  - OP_NOP
- The package is shared with the debug unit and the ID decoder.
- One sub-module, `load_use_detect`, is purely combinational: inputs i_id_rs, i_id_rt, i_ex_rt, i_ex_mem_read; output stall.
- The FSM, drain counter and cycle counter live in the top module.

## Test plan
- Reset, then i_run pulse with no hazards: o_pc_enable = o_pipe_enable = 1 from the next cycle; o_busy = 1; o_cycle_count increments by 1 per cycle.
- In RUN, i_ex_mem_read = 1, i_ex_rt = 5, i_id_rs = 5 for one cycle: o_pc_enable = 0, o_if_id_enable = 0, o_id_ex_flush = 1 in that cycle only. Repeat with i_ex_rt = 0: no stall.
- From IDLE, three i_step pulses separated by idle cycles: exactly three cycles with o_pipe_enable = 1, each followed by IDLE; o_cycle_count = 3.
- In RUN, i_id_opcode = 6'b111111 at cycle t: fetch is frozen at t; DRAIN for 3 cycles with o_id_ex_flush = 1; o_halted = 1 at t+4. Subsequent i_run is ignored.
- i_reset asserted asynchronously during the second DRAIN cycle: all outputs 0 immediately; state IDLE; o_cycle_count = 0. A fresh i_run restarts RUN.
- Build without PIPE_EXEC_CTRL_CYCLE_COUNT_EN and run the RUN scenario: o_cycle_count stays 0 throughout.
